// File: rtl/uart_param.sv
// Parametrised full-duplex UART core: independent TX and RX engines sharing clk/rst_n.
// Frame: start, DATA_BITS LSB first, optional odd/even parity, STOP_BITS stop bits.
module uart_param #(
    parameter int unsigned CLK_DIV   = 434,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx,
    input  logic                 rx,
    output logic                 rx_valid,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err
);

    localparam int unsigned    CW        = $clog2(CLK_DIV);
    localparam logic [CW-1:0]  BIT_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0]  HALF_LAST = CW'(CLK_DIV / 2 - 1);
    localparam logic [3:0]     DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]     STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic           HAS_PAR   = (PARITY != 0);
    localparam logic           PAR_ODD   = (PARITY == 1);

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH} rx_state_e;

    tx_state_e              tx_state_q, tx_state_d;
    logic [CW-1:0]          tx_cnt_q, tx_cnt_d;
    logic [3:0]             tx_idx_q, tx_idx_d;
    logic [DATA_BITS-1:0]   tx_shift_q, tx_shift_d;
    logic                   tx_par_q, tx_par_d;
    logic                   tx_q, tx_d;
    logic                   tx_tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_idx_q   <= tx_idx_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            tx_q       <= tx_d;
        end
    end

    assign tx_tick = (tx_cnt_q == '0);

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_tick ? BIT_LAST : tx_cnt_q - 1'b1;
        tx_idx_d   = tx_idx_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        tx_d       = tx_q;
        case (tx_state_q)
            TX_IDLE: begin
                tx_d     = 1'b1;
                tx_cnt_d = BIT_LAST;
                if (tx_valid) begin
                    tx_state_d = TX_START;
                    tx_shift_d = tx_data;
                    tx_par_d   = ^tx_data ^ PAR_ODD;
                    tx_d       = 1'b0;
                end
            end
            TX_START: if (tx_tick) begin
                tx_state_d = TX_DATA;
                tx_idx_d   = '0;
                tx_d       = tx_shift_q[0];
            end
            TX_DATA: if (tx_tick) begin
                if (tx_idx_q == DATA_LAST) begin
                    tx_idx_d = '0;
                    if (HAS_PAR) begin
                        tx_state_d = TX_PARITY;
                        tx_d       = tx_par_q;
                    end else begin
                        tx_state_d = TX_STOP;
                        tx_d       = 1'b1;
                    end
                end else begin
                    tx_idx_d   = tx_idx_q + 1'b1;
                    tx_shift_d = tx_shift_q >> 1;
                    tx_d       = tx_shift_q[1];
                end
            end
            TX_PARITY: if (tx_tick) begin
                tx_state_d = TX_STOP;
                tx_idx_d   = '0;
                tx_d       = 1'b1;
            end
            TX_STOP: if (tx_tick) begin
                tx_d = 1'b1;
                if (tx_idx_q == STOP_LAST) tx_state_d = TX_IDLE;
                else                       tx_idx_d   = tx_idx_q + 1'b1;
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_comb begin
        tx_ready = (tx_state_q == TX_IDLE);
        tx       = tx_q;
    end

    // Two-flop synchroniser plus a delayed copy for falling-edge detection.
    logic rx_meta_q, rxs_q, rxs_prev_q;

    rx_state_e              rx_state_q, rx_state_d;
    logic [CW-1:0]          rx_cnt_q, rx_cnt_d;
    logic [3:0]             rx_idx_q, rx_idx_d;
    logic [DATA_BITS-1:0]   rx_shift_q, rx_shift_d;
    logic                   rx_perr_q, rx_perr_d;
    logic                   rx_ferr_q, rx_ferr_d;
    logic                   rx_valid_q, rx_valid_d;
    logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
    logic                   rx_parity_err_q, rx_parity_err_d;
    logic                   rx_frame_err_q, rx_frame_err_d;
    logic                   rx_tick, stop_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q       <= 1'b1;
            rxs_q           <= 1'b1;
            rxs_prev_q      <= 1'b1;
            rx_state_q      <= RX_IDLE;
            rx_cnt_q        <= '0;
            rx_idx_q        <= '0;
            rx_shift_q      <= '0;
            rx_perr_q       <= 1'b0;
            rx_ferr_q       <= 1'b0;
            rx_valid_q      <= 1'b0;
            rx_data_q       <= '0;
            rx_parity_err_q <= 1'b0;
            rx_frame_err_q  <= 1'b0;
        end else begin
            rx_meta_q       <= rx;
            rxs_q           <= rx_meta_q;
            rxs_prev_q      <= rxs_q;
            rx_state_q      <= rx_state_d;
            rx_cnt_q        <= rx_cnt_d;
            rx_idx_q        <= rx_idx_d;
            rx_shift_q      <= rx_shift_d;
            rx_perr_q       <= rx_perr_d;
            rx_ferr_q       <= rx_ferr_d;
            rx_valid_q      <= rx_valid_d;
            rx_data_q       <= rx_data_d;
            rx_parity_err_q <= rx_parity_err_d;
            rx_frame_err_q  <= rx_frame_err_d;
        end
    end

    assign rx_tick  = (rx_cnt_q == '0);
    assign stop_err = rx_ferr_q | ~rxs_q;

    always_comb begin
        rx_state_d      = rx_state_q;
        rx_cnt_d        = rx_tick ? BIT_LAST : rx_cnt_q - 1'b1;
        rx_idx_d        = rx_idx_q;
        rx_shift_d      = rx_shift_q;
        rx_perr_d       = rx_perr_q;
        rx_ferr_d       = rx_ferr_q;
        rx_valid_d      = 1'b0;
        rx_data_d       = rx_data_q;
        rx_parity_err_d = rx_parity_err_q;
        rx_frame_err_d  = rx_frame_err_q;
        case (rx_state_q)
            RX_IDLE: if (!rxs_q && rxs_prev_q) begin
                rx_state_d = RX_START;
                rx_cnt_d   = HALF_LAST;
            end
            RX_START: if (rx_tick) begin
                rx_state_d = rxs_q ? RX_IDLE : RX_DATA;
                rx_idx_d   = '0;
                rx_perr_d  = 1'b0;
                rx_ferr_d  = 1'b0;
            end
            RX_DATA: if (rx_tick) begin
                rx_shift_d = {rxs_q, rx_shift_q[DATA_BITS-1:1]};
                if (rx_idx_q == DATA_LAST) begin
                    rx_idx_d   = '0;
                    rx_state_d = HAS_PAR ? RX_PARITY : RX_STOP;
                end else begin
                    rx_idx_d = rx_idx_q + 1'b1;
                end
            end
            RX_PARITY: if (rx_tick) begin
                rx_perr_d  = ^rx_shift_q ^ rxs_q ^ PAR_ODD;
                rx_state_d = RX_STOP;
            end
            RX_STOP: if (rx_tick) begin
                rx_ferr_d = stop_err;
                if (rx_idx_q == STOP_LAST) begin
                    rx_valid_d      = 1'b1;
                    rx_data_d       = rx_shift_q;
                    rx_parity_err_d = HAS_PAR & rx_perr_q;
                    rx_frame_err_d  = stop_err;
                    // A low line after a bad stop is a break: hold off until it idles.
                    rx_state_d      = stop_err ? RX_WAIT_HIGH : RX_IDLE;
                end else begin
                    rx_idx_d = rx_idx_q + 1'b1;
                end
            end
            RX_WAIT_HIGH: if (rxs_q) rx_state_d = RX_IDLE;
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        rx_valid      = rx_valid_q;
        rx_data       = rx_data_q;
        rx_parity_err = rx_parity_err_q;
        rx_frame_err  = rx_frame_err_q;
    end

endmodule
